// File: rtl/beta_irqctl.sv
// Prioritised interrupt controller: synchronised edge/level channels, a mask, and a
// request/ack/eoi handshake to the core. The lowest-indexed eligible channel wins.
module beta_irqctl #(
  parameter int          NIRQ       = 8,
  parameter int          WIDTH      = 32,
  parameter logic [31:0] VEC_BASE   = 32'h8000_0008,
  parameter int          VEC_STRIDE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NIRQ-1:0]  irq_in,
  input  logic             supervisor,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  output logic [WIDTH-1:0] cfg_rdata,
  input  logic             irq_ack,
  input  logic             eoi,
  output logic             irq_req,
  output logic [WIDTH-1:0] irq_vec,
  output logic [4:0]       irq_id
);

  localparam logic [WIDTH-1:0] VBASE_W   = WIDTH'(VEC_BASE);
  localparam logic [WIDTH-1:0] VSTRIDE_W = WIDTH'(VEC_STRIDE);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  state_t          state_q;
  logic            irq_req_q;
  logic [4:0]      irq_id_q;
  logic [NIRQ-1:0] sync1_q, sync2_q, prev_q;
  logic [NIRQ-1:0] mask_q, mode_q, pend_q, pend_d;
  logic [NIRQ-1:0] rise, clr, id_onehot;
  logic [31:0]     elig32;
  logic            win_vld, cur_elig, ack_take;
  logic [4:0]      win_idx;
  logic            unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  always_comb begin
    elig32  = 32'(pend_q & mask_q);
    win_vld = 1'b0;
    win_idx = 5'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (elig32[i]) begin
        win_vld = 1'b1;
        win_idx = 5'(i);
      end
    end
  end

  assign cur_elig  = elig32[irq_id_q];
  assign ack_take  = (state_q == S_REQ) && irq_ack;
  assign id_onehot = NIRQ'(32'd1 << irq_id_q);
  assign rise      = sync2_q & ~prev_q;

  // Edge bits hold until cleared (a same-cycle rise wins); level bits track the line.
  always_comb begin
    clr = '0;
    if (cfg_we && cfg_addr == 2'd1) clr = cfg_wdata[NIRQ-1:0];
    if (ack_take) clr = clr | id_onehot;
    pend_d = (mode_q & (rise | (pend_q & ~clr))) | (~mode_q & sync2_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pend_q  <= pend_d;
      if (cfg_we && cfg_addr == 2'd0) mask_q <= cfg_wdata[NIRQ-1:0];
      if (cfg_we && cfg_addr == 2'd2) mode_q <= cfg_wdata[NIRQ-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      irq_req_q <= 1'b0;
      irq_id_q  <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_vld && !supervisor) begin
            state_q   <= S_REQ;
            irq_req_q <= 1'b1;
            irq_id_q  <= win_idx;
          end
        end
        S_REQ: begin
          // Ack takes priority over the latched channel dropping out in the same cycle.
          if (irq_ack) begin
            state_q   <= S_SERVICE;
            irq_req_q <= 1'b0;
          end else if (!cur_elig) begin
            state_q   <= S_IDLE;
            irq_req_q <= 1'b0;
          end
        end
        S_SERVICE: begin
          if (eoi) state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          irq_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0: cfg_rdata[NIRQ-1:0] = mask_q;
      2'd1: cfg_rdata[NIRQ-1:0] = pend_q;
      2'd2: cfg_rdata[NIRQ-1:0] = mode_q;
      default: begin
        cfg_rdata[WIDTH-1] = (state_q != S_IDLE);
        cfg_rdata[4:0]     = irq_id_q;
      end
    endcase
  end

  assign irq_req = irq_req_q;
  assign irq_id  = irq_id_q;
  assign irq_vec = VBASE_W + WIDTH'(irq_id_q) * VSTRIDE_W;

endmodule

// File: tb/tb_beta_irqctl.sv
// Directed bench for beta_irqctl: stimulus queues expected requests, a monitor checks each new irq_req.
module tb_beta_irqctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq_in = '0;
  logic        supervisor = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic        irq_ack = 1'b0;
  logic        eoi = 1'b0;
  logic        irq_req;
  logic [31:0] irq_vec;
  logic [4:0]  irq_id;

  typedef struct {
    logic [4:0]  id;
    logic [31:0] vec;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic prev_req = 1'b0;

  beta_irqctl dut (
    .clk(clk), .reset(rst), .irq_in(irq_in), .supervisor(supervisor),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .irq_ack(irq_ack), .eoi(eoi), .irq_req(irq_req), .irq_vec(irq_vec), .irq_id(irq_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every new request is matched against the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
      end else begin
        if (irq_req && !prev_req) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_req: got id %0d with no request expected", irq_id);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("req_id", 32'(irq_id), 32'(e.id));
            chk("req_vec", irq_vec, e.vec);
            if (e.cyc >= 0) chk("req_cycle", cyc, e.cyc);
          end
        end
        prev_req = irq_req;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick(1);
    cfg_we = 1'b0; cfg_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic push(input logic [4:0] id, input logic [31:0] vec, input int c);
    exp_t e;
    e.id = id; e.vec = vec; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic wait_req(input int maxc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!irq_req && n < maxc);
    if (!irq_req) begin
      tests++;
      fails++;
      $display("FAIL wait_req_timeout: got no irq_req after %0d cycles, required a request", n);
    end
    tick(1);
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; tick(1); eoi = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int c0;

    // Reset values
    #2;
    chk("rst_irq_req", 32'(irq_req), 32'd0);
    chk("rst_irq_vec", irq_vec, 32'h8000_0008);
    chk("rst_irq_id", 32'(irq_id), 32'd0);
    rd(2'd0, d); chk("rst_mask", d, 32'd0);
    rd(2'd3, d); chk("rst_cause", d, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick(2);

    // Single-cycle edge pulse on channel 0: request four edges after first sample
    cfg_write(2'd0, 32'h01);
    cfg_write(2'd2, 32'h01);
    tick(1);
    c0 = cyc;
    push(5'd0, 32'h8000_0008, c0 + 4);
    irq_in = 8'h01;
    tick(1);
    irq_in = 8'h00;
    wait_req(10);
    pulse_ack();
    chk("svc_req_low", 32'(irq_req), 32'd0);
    rd(2'd3, d); chk("svc_cause", d, 32'h8000_0000);
    rd(2'd1, d); chk("ack_clears_edge_pend", d, 32'd0);
    pulse_eoi();
    tick(5);
    chk("no_rereq_edge", 32'(irq_req), 32'd0);
    rd(2'd3, d); chk("idle_cause_valid", 32'(d[31]), 32'd0);

    // Level channels 3 and 5: lowest wins, re-requests while still pending
    cfg_write(2'd2, 32'h00);
    cfg_write(2'd0, 32'hFF);
    push(5'd3, 32'h8000_0014, -1);
    irq_in = 8'h28;
    wait_req(10);
    pulse_ack();
    push(5'd3, 32'h8000_0014, -1);
    pulse_eoi();
    wait_req(10);
    pulse_ack();
    irq_in = 8'h00;
    tick(4);
    pulse_eoi();
    tick(5);
    chk("level_dropped_no_req", 32'(irq_req), 32'd0);

    // Latched id holds in REQ when a higher-priority channel arrives
    push(5'd5, 32'h8000_001C, -1);
    irq_in = 8'h20;
    wait_req(10);
    irq_in = 8'h22;
    tick(6);
    chk("id_held_in_req", 32'(irq_id), 32'd5);
    chk("req_held", 32'(irq_req), 32'd1);
    pulse_ack();
    push(5'd1, 32'h8000_000C, -1);
    pulse_eoi();
    wait_req(10);
    pulse_ack();
    irq_in = 8'h00;
    tick(4);
    pulse_eoi();
    tick(3);

    // Supervisor blocks the IDLE->REQ transition only
    supervisor = 1'b1;
    irq_in = 8'h04;
    tick(8);
    chk("supervisor_blocks", 32'(irq_req), 32'd0);
    c0 = cyc;
    push(5'd2, 32'h8000_0010, c0 + 1);
    supervisor = 1'b0;
    wait_req(10);
    pulse_ack();
    irq_in = 8'h00;
    tick(4);
    pulse_eoi();
    tick(3);

    // Clearing a latched edge channel withdraws the request
    cfg_write(2'd2, 32'h10);
    push(5'd4, 32'h8000_0018, -1);
    irq_in = 8'h10;
    wait_req(10);
    rd(2'd1, d); chk("edge4_pending", d, 32'h10);
    cfg_write(2'd1, 32'h10);
    rd(2'd1, d); chk("pend_write_clear", d, 32'h00);
    tick(1);
    chk("withdraw_req_low", 32'(irq_req), 32'd0);
    rd(2'd3, d); chk("withdraw_cause_valid", 32'(d[31]), 32'd0);
    tick(5);
    chk("withdraw_no_rereq", 32'(irq_req), 32'd0);

    // Reset while in SERVICE
    push(5'd0, 32'h8000_0008, -1);
    irq_in = 8'h11;
    wait_req(10);
    pulse_ack();
    rd(2'd3, d); chk("pre_rst_cause", d, 32'h8000_0000);
    rst = 1'b1;
    #1;
    chk("rst_mid_req", 32'(irq_req), 32'd0);
    rd(2'd0, d); chk("rst_mid_mask", d, 32'd0);
    rd(2'd1, d); chk("rst_mid_pend", d, 32'd0);
    rd(2'd2, d); chk("rst_mid_mode", d, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(6);
    chk("post_rst_no_req", 32'(irq_req), 32'd0);
    rd(2'd3, d); chk("post_rst_cause", d, 32'd0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
